// File: rtl/display_scheduler_pkg.sv
// Shared types for the trace display scheduler: FSM state encoding, the buffered sample
// layout, and a few CPU opcode values that trace samples commonly carry.
package display_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        HELD  = 2'd2,
        BLANK = 2'd3
    } disp_sched_state_t;

    typedef struct packed {
        logic [7:0] op_code;
        logic [7:0] r16;
    } trace_sample_t;

    localparam int SAMPLE_W = $bits(trace_sample_t);

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LDI = 8'h01;
    localparam logic [7:0] OP_ORI = 8'h02;
    localparam logic [7:0] OP_OUT = 8'h03;

    function automatic int max_cycles(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// Bundle between the CPU trace port, the step controls and the 7-segment display.
// The master side is the CPU/control side; the scheduler uses the slave modport.
interface display_scheduler_if;
    logic       sample_valid;
    logic [7:0] sample_op_code;
    logic [7:0] sample_r16;
    logic       sample_ready;
    logic       step_mode;
    logic       step;
    logic       display_enable;
    logic [7:0] op_code;
    logic [7:0] r16;
    logic [7:0] dropped_count;

    modport master (
        output sample_valid,
        output sample_op_code,
        output sample_r16,
        output step_mode,
        output step,
        input  sample_ready,
        input  display_enable,
        input  op_code,
        input  r16,
        input  dropped_count
    );

    modport slave (
        input  sample_valid,
        input  sample_op_code,
        input  sample_r16,
        input  step_mode,
        input  step,
        output sample_ready,
        output display_enable,
        output op_code,
        output r16,
        output dropped_count
    );
endinterface

// File: rtl/display_scheduler_fifo.sv
// Show-ahead synchronous FIFO buffering trace samples; dout always reflects the head entry.
// Push when full and pop when empty are ignored, so callers may strobe freely.
module display_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/display_scheduler.sv
// Paces CPU trace samples onto the 7-segment display: timed hold or manual step per entry,
// with a blank gap between entries so repeated values remain visible.
//   state | meaning
//   IDLE  | nothing shown yet, waiting for the first sample
//   SHOW  | entry displayed, hold timer running (auto) or waiting for step
//   HELD  | hold expired with nothing queued, last entry stays visible
//   BLANK | display dark for the gap before the next entry
module display_scheduler
    import display_scheduler_pkg::*;
#(
    parameter int HOLD_CYCLES  = 25_000_000,
    parameter int BLANK_CYCLES = 2_500_000,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                clock,
    input  logic                reset_s2,
    display_scheduler_if.slave  disp_bus
);
    localparam int TW = $clog2(max_cycles(HOLD_CYCLES, BLANK_CYCLES) + 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);

    disp_sched_state_t state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    trace_sample_t     shown_q, shown_d;
    logic              enable_q, enable_d;
    logic [7:0]        dropped_q, dropped_d;

    trace_sample_t fifo_din, fifo_dout;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;

    assign fifo_din.op_code = disp_bus.sample_op_code;
    assign fifo_din.r16     = disp_bus.sample_r16;
    assign fifo_push        = disp_bus.sample_valid & ~fifo_full;

    display_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clock),
        .rst   (reset_s2),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        shown_d  = shown_q;
        enable_d = enable_q;
        fifo_pop = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shown_d  = fifo_dout;
                    timer_d  = '0;
                    enable_d = 1'b1;
                    state_d  = SHOW;
                end
            end
            SHOW: begin
                // Step mode parks the timer at zero so leaving it restarts a full hold.
                if (disp_bus.step_mode) begin
                    timer_d = '0;
                    if (disp_bus.step && !fifo_empty) begin
                        enable_d = 1'b0;
                        state_d  = BLANK;
                    end
                end else if (timer_q == HOLD_LAST) begin
                    timer_d = '0;
                    if (fifo_empty) begin
                        enable_d = 1'b1;
                        state_d  = HELD;
                    end else begin
                        enable_d = 1'b0;
                        state_d  = BLANK;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            HELD: begin
                timer_d = '0;
                if (!fifo_empty && (!disp_bus.step_mode || disp_bus.step)) begin
                    enable_d = 1'b0;
                    state_d  = BLANK;
                end
            end
            BLANK: begin
                if (timer_q == BLANK_LAST) begin
                    timer_d = '0;
                    if (fifo_empty) begin
                        enable_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        fifo_pop = 1'b1;
                        shown_d  = fifo_dout;
                        enable_d = 1'b1;
                        state_d  = SHOW;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                timer_d  = '0;
                enable_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // Full is judged at cycle start, so a same-cycle pop never rescues an overflow push.
    always_comb begin
        dropped_d = dropped_q;
        if (disp_bus.sample_valid && fifo_full && (dropped_q != 8'hFF)) begin
            dropped_d = dropped_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset_s2) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            shown_q   <= '0;
            enable_q  <= 1'b0;
            dropped_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            shown_q   <= shown_d;
            enable_q  <= enable_d;
            dropped_q <= dropped_d;
        end
    end

    assign disp_bus.sample_ready   = ~fifo_full;
    assign disp_bus.display_enable = enable_q;
    assign disp_bus.op_code        = shown_q.op_code;
    assign disp_bus.r16            = shown_q.r16;
    assign disp_bus.dropped_count  = dropped_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with short hold/blank times; a monitor pops the
// scoreboard whenever a new entry lights up and checks order, hold and blank lengths.
module tb_display_scheduler;
    import display_scheduler_pkg::*;

    localparam int HOLD  = 4;
    localparam int BLANK = 2;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset_s2;
    int   tests = 0;
    int   fails = 0;

    display_scheduler_if disp_if ();

    display_scheduler #(
        .HOLD_CYCLES  (HOLD),
        .BLANK_CYCLES (BLANK),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock    (clock),
        .reset_s2 (reset_s2),
        .disp_bus (disp_if)
    );

    always #5 clock = ~clock;

    trace_sample_t sb_q[$];
    bit            chk_timing = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        reset_s2 = 1'b1;
        tick();
        sb_q.delete();
        reset_s2 = 1'b0;
    endtask

    task automatic drive_push(input logic [7:0] op, input logic [7:0] val, input bit accepted);
        trace_sample_t s;
        s.op_code = op;
        s.r16     = val;
        disp_if.sample_valid   = 1'b1;
        disp_if.sample_op_code = op;
        disp_if.sample_r16     = val;
        if (accepted) sb_q.push_back(s);
        tick();
        disp_if.sample_valid = 1'b0;
    endtask

    // Monitor: samples 2 time units after each rising edge.
    bit            mon_prev_en = 1'b0;
    bit            mon_after_blank = 1'b0;
    int            mon_on_len = 0;
    int            mon_off_len = 0;
    trace_sample_t mon_exp;

    always begin
        @(posedge clock);
        #2;
        if (reset_s2) begin
            mon_prev_en     = 1'b0;
            mon_after_blank = 1'b0;
            mon_on_len      = 0;
            mon_off_len     = 0;
        end else begin
            if (disp_if.display_enable && !mon_prev_en) begin
                if (mon_after_blank) check("blank_len", 32'(mon_off_len), 32'(BLANK));
                check("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    mon_exp = sb_q.pop_front();
                    check("sb_order", 32'({disp_if.op_code, disp_if.r16}), 32'(mon_exp));
                end
                mon_on_len = 1;
            end else if (disp_if.display_enable) begin
                mon_on_len++;
            end
            if (!disp_if.display_enable && mon_prev_en) begin
                if (chk_timing) check("hold_len", 32'(mon_on_len), 32'(HOLD));
                mon_after_blank = 1'b1;
                mon_off_len     = 1;
            end else if (!disp_if.display_enable) begin
                mon_off_len++;
            end
            mon_prev_en = disp_if.display_enable;
        end
    end

    initial begin
        bit ok;
        reset_s2               = 1'b1;
        disp_if.sample_valid   = 1'b0;
        disp_if.sample_op_code = 8'h00;
        disp_if.sample_r16     = 8'h00;
        disp_if.step_mode      = 1'b0;
        disp_if.step           = 1'b0;
        tick(2);
        reset_s2 = 1'b0;
        tick();
        check("rst_enable", 32'(disp_if.display_enable), 32'd0);
        check("rst_op_code", 32'(disp_if.op_code), 32'h00);
        check("rst_r16", 32'(disp_if.r16), 32'h00);
        check("rst_ready", 32'(disp_if.sample_ready), 32'd1);
        check("rst_dropped", 32'(disp_if.dropped_count), 32'd0);

        // Single sample from IDLE: one-edge latency, then held indefinitely.
        chk_timing = 1'b1;
        drive_push(OP_LDI, 8'h02, 1'b1);
        check("single_lat_n", 32'(disp_if.display_enable), 32'd0);
        tick();
        check("single_lat_en", 32'(disp_if.display_enable), 32'd1);
        check("single_op", 32'(disp_if.op_code), 32'(OP_LDI));
        check("single_r16", 32'(disp_if.r16), 32'h02);
        ok = 1'b1;
        for (int i = 0; i < 104; i++) begin
            tick();
            if (!(disp_if.display_enable === 1'b1 && disp_if.op_code === OP_LDI &&
                  disp_if.r16 === 8'h02)) ok = 1'b0;
        end
        check("single_held", 32'(ok), 32'd1);
        check("single_drain", 32'(sb_q.size()), 32'd0);

        // Burst: timing and ordering checked by the monitor.
        do_reset();
        drive_push(OP_LDI, 8'h01, 1'b1);
        drive_push(OP_ORI, 8'h20, 1'b1);
        drive_push(OP_OUT, 8'h20, 1'b1);
        tick(30);
        check("burst_drain", 32'(sb_q.size()), 32'd0);
        check("burst_last_en", 32'(disp_if.display_enable), 32'd1);
        check("burst_last_op", 32'(disp_if.op_code), 32'(OP_OUT));

        // Overflow in step mode with one entry already on display.
        chk_timing = 1'b0;
        do_reset();
        disp_if.step_mode = 1'b1;
        drive_push(8'h40, 8'h90, 1'b1);
        tick(2);
        for (int i = 1; i <= 6; i++) begin
            check("ovf_ready", 32'(disp_if.sample_ready), 32'(i <= DEPTH));
            drive_push(8'(8'h40 + i), 8'(8'h90 + i), i <= DEPTH);
        end
        check("ovf_ready_low", 32'(disp_if.sample_ready), 32'd0);
        check("ovf_dropped2", 32'(disp_if.dropped_count), 32'd2);
        disp_if.sample_valid   = 1'b1;
        disp_if.sample_op_code = 8'hEE;
        disp_if.sample_r16     = 8'hEE;
        tick(252);
        check("ovf_dropped254", 32'(disp_if.dropped_count), 32'd254);
        tick(48);
        disp_if.sample_valid = 1'b0;
        check("ovf_dropped_sat", 32'(disp_if.dropped_count), 32'd255);
        check("step_hold_en", 32'(disp_if.display_enable), 32'd1);
        check("step_hold_op", 32'(disp_if.op_code), 32'h40);

        for (int k = 1; k <= DEPTH; k++) begin
            disp_if.step = 1'b1;
            tick();
            disp_if.step = 1'b0;
            check("step_blank0", 32'(disp_if.display_enable), 32'd0);
            tick();
            check("step_blank1", 32'(disp_if.display_enable), 32'd0);
            tick();
            check("step_next_en", 32'(disp_if.display_enable), 32'd1);
            check("step_next_op", 32'(disp_if.op_code), 32'(8'h40 + k));
            tick(5);
            check("step_wait_r16", 32'(disp_if.r16), 32'(8'h90 + k));
        end
        disp_if.step = 1'b1;
        tick();
        disp_if.step = 1'b0;
        tick(5);
        check("step_empty_en", 32'(disp_if.display_enable), 32'd1);
        check("step_empty_op", 32'(disp_if.op_code), 32'h44);
        check("step_empty_r16", 32'(disp_if.r16), 32'h94);
        check("step_drain", 32'(sb_q.size()), 32'd0);
        check("step_ready", 32'(disp_if.sample_ready), 32'd1);
        check("step_dropped_keep", 32'(disp_if.dropped_count), 32'd255);

        // Reset in the middle of SHOW with three samples buffered.
        disp_if.step_mode = 1'b0;
        chk_timing = 1'b1;
        do_reset();
        drive_push(8'h60, 8'hA0, 1'b1);
        drive_push(8'h61, 8'hA1, 1'b1);
        drive_push(8'h62, 8'hA2, 1'b1);
        drive_push(8'h63, 8'hA3, 1'b1);
        check("mid_show_en", 32'(disp_if.display_enable), 32'd1);
        check("mid_show_op", 32'(disp_if.op_code), 32'h60);
        do_reset();
        check("mid_rst_en", 32'(disp_if.display_enable), 32'd0);
        check("mid_rst_op", 32'(disp_if.op_code), 32'h00);
        check("mid_rst_r16", 32'(disp_if.r16), 32'h00);
        check("mid_rst_ready", 32'(disp_if.sample_ready), 32'd1);
        tick(6);
        check("mid_rst_fifo_empty", 32'(disp_if.display_enable), 32'd0);
        drive_push(OP_OUT, 8'h5A, 1'b1);
        check("fresh_lat_n", 32'(disp_if.display_enable), 32'd0);
        tick();
        check("fresh_en", 32'(disp_if.display_enable), 32'd1);
        check("fresh_op", 32'(disp_if.op_code), 32'(OP_OUT));
        check("fresh_r16", 32'(disp_if.r16), 32'h5A);
        tick(10);
        check("fresh_drain", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
